// File: rtl/nv_vmux_pipe_pkg.sv
// Shared constants and select-width helper for the nv_vmux_pipe channel selector.
package nv_vmux_pipe_pkg;

    localparam int unsigned N_MIN = 2;
    localparam int unsigned N_MAX = 16;
    localparam int unsigned W_MIN = 1;
    localparam int unsigned W_MAX = 1024;

    // clog2 with a floor of one bit, so a 2:1 mux still has a real select line
    function automatic int unsigned sel_width(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/nv_vmux_rr_arb.sv
// Round-robin grant generator for nv_vmux_pipe: lowest valid index at or after ptr, wrapping.
module nv_vmux_rr_arb #(
    parameter int unsigned N  = 2,
    parameter int unsigned SW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  pvld,
    input  logic          advance,
    output logic [SW-1:0] grant
);

    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_nxt;
    logic          found;
    int unsigned   idx;
    int unsigned   nxt;

    // Scan N positions starting at ptr; the first valid one wins, else park on ptr
    always_comb begin
        grant = ptr;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && pvld[SW'(idx)]) begin
                grant = SW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        nxt     = 32'(grant) + 1;
        ptr_nxt = (nxt >= N) ? '0 : SW'(nxt);
    end

    // Pointer moves past the winner only when a beat is actually taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/nv_vmux_pipe.sv
// N-way registered channel selector with valid/ready flow control.
// Define NV_VMUX_RR_EN to replace the static sel port with a round-robin arbiter.
module nv_vmux_pipe
    import nv_vmux_pipe_pkg::*;
#(
    parameter  int unsigned N  = 2,
    parameter  int unsigned W  = 8,
    localparam int unsigned SW = sel_width(N)
) (
    input  logic            nvdla_core_clk,
    input  logic            nvdla_core_rstn,
    input  logic [N-1:0]    in_pvld,
    output logic [N-1:0]    in_prdy,
    input  logic [N*W-1:0]  in_pd,
    input  logic [SW-1:0]   sel,
    output logic            out_pvld,
    input  logic            out_prdy,
    output logic [W-1:0]    out_pd,
    output logic [SW-1:0]   out_src
);

    localparam int unsigned NSEL = 32'd1 << SW;

    if (N < N_MIN || N > N_MAX || W < W_MIN || W > W_MAX) begin : g_bad_param
        $error("nv_vmux_pipe: N or W outside legal range");
    end

    logic [SW-1:0]   g;
    logic [NSEL-1:0] chan_ok;
    logic [NSEL-1:0] pvld_ext;
    logic [W-1:0]    pd_arr [NSEL];
    logic            can_take;
    logic            grant_valid;
    logic            load;

    // Pad the channel set to a full power of two so any select code indexes safely
    for (genvar i = 0; i < NSEL; i++) begin : g_chan
        if (i < N) begin : g_live
            assign chan_ok[i]  = 1'b1;
            assign pvld_ext[i] = in_pvld[i];
            assign pd_arr[i]   = in_pd[i*W +: W];
        end else begin : g_pad
            assign chan_ok[i]  = 1'b0;
            assign pvld_ext[i] = 1'b0;
            assign pd_arr[i]   = '0;
        end
    end

`ifdef NV_VMUX_RR_EN
    logic unused_sel;
    assign unused_sel = ^sel;

    nv_vmux_rr_arb #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .clk     (nvdla_core_clk),
        .rst_n   (nvdla_core_rstn),
        .pvld    (in_pvld),
        .advance (load),
        .grant   (g)
    );
`else
    assign g = sel;
`endif

    // Reset gates ready so no producer sees a handshake while the stage is held clear
    assign can_take    = nvdla_core_rstn && (!out_pvld || out_prdy);
    assign grant_valid = chan_ok[g] && pvld_ext[g];
    assign load        = can_take && grant_valid;

    always_comb begin
        in_prdy = '0;
        for (int unsigned i = 0; i < N; i++) begin
            in_prdy[i] = can_take && chan_ok[g] && (g == SW'(i));
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            out_pvld <= 1'b0;
            out_pd   <= '0;
            out_src  <= '0;
        end else if (load) begin
            out_pvld <= 1'b1;
            out_pd   <= pd_arr[g];
            out_src  <= g;
        end else if (out_prdy) begin
            out_pvld <= 1'b0;
        end
    end

endmodule

// File: doc/nv_vmux_pipe.md
# nv_vmux_pipe

Parametrised N-way, W-bit registered multiplexer with valid/ready handshake; generalises the 2:1 combinational mux cell into a flow-controlled, one-stage pipelined channel selector. Sits between multiple producer pipes and a single consumer pipe in the core clock domain. Selection is by an explicit select port, or by a built-in round-robin arbiter when compiled in.

## Interface
- N, 2, number of input channels (2..16)
- W, 8, data width per channel (1..1024)
- SW, derived, select width = max(1, clog2(N)); not overridable

- nvdla_core_clk  in  1  core clock; all state on rising edge
- nvdla_core_rstn  in  1  asynchronous, active-low reset
- in_pvld  in  N  per-channel valid
- in_prdy  out  N  per-channel ready
- in_pd  in  N*W  channel i data at bits [i*W +: W]
- sel  in  SW  static select; unused when round-robin is compiled in
- out_pvld  out  1  output valid
- out_prdy  in  1  output ready
- out_pd  out  W  output data
- out_src  out  SW  index of the channel that supplied out_pd

## Operation
- Reset: out_pvld=0, out_pd=0, out_src=0, round-robin pointer=0.
- Effective grant g each cycle: sel (static mode) or arbiter grant (round-robin mode).
- load = (!out_pvld || out_prdy) && grant_valid, where grant_valid = (g < N) && in_pvld[g].
- in_prdy[i] = (i == g) && (g < N) && (!out_pvld || out_prdy); in_prdy is independent of in_pvld for the granted channel; all other bits 0.
- On load: out_pd <= in_pd[g], out_src <= g, out_pvld <= 1.
- If out_prdy && out_pvld && !load: out_pvld <= 0; out_pd/out_src hold.
- If out_pvld && !out_prdy: register holds; all in_prdy 0.
- sel >= N (non-power-of-two N): no channel selected, no load, all in_prdy 0.
- sel may change any cycle; only the value at a transfer edge matters.
- Data is never dropped or duplicated: every in_pvld&&in_prdy edge yields exactly one output beat.

## Timing
- Latency: 1 cycle from input transfer to out_pvld.
- Throughput: 1 beat/cycle with out_prdy held high.
- in_prdy and grant are combinational from sel/in_pvld/out_pvld/out_prdy; no combinational path from in_pd to out_pd.
- Reset asserted mid-transfer: output register clears immediately (asynchronously); in-flight beat discarded.

## Configuration
- NV_VMUX_RR_EN defined: round-robin arbiter drives g; sel ignored. Grant = lowest index i ≥ ptr (wrapping modulo N) with in_pvld[i]=1; if none valid, g=ptr and grant_valid=0. On a load, ptr <= (g+1) mod N; otherwise ptr holds. No channel waits more than N-1 transfers.
- Not defined: g = sel; no pointer state.

## Structure
- Shared package: SW derivation function (clog2 with minimum 1), N/W legal-range constants.
- One sub-module: nv_vmux_rr_arb (N in_pvld, ptr register, grant index, advance strobe), instantiated only under NV_VMUX_RR_EN.

## Test plan
- Reset: rstn low with all in_pvld=1 -> out_pvld=0, out_pd=0, out_src=0, in_prdy=0 throughout.
- Static, N=4 W=8: sel=2, in_pvld=4'b0100, in_pd ch2=0xA5, out_prdy=1 -> next cycle out_pvld=1, out_pd=0xA5, out_src=2; in_prdy=4'b0100.
- Backpressure: out_pvld=1, out_prdy=0 for 3 cycles with ch1 valid and sel=1 -> in_prdy=0, out_pd stable; out_prdy=1 -> ch1 beat loads same cycle as drain, no bubble.
- Out-of-range: N=3, sel=3, all valid -> in_prdy=0, out_pvld stays 0.
- Round-robin (NV_VMUX_RR_EN, N=4): all channels continuously valid, out_prdy=1 -> out_src sequence 0,1,2,3,0,...; then only ch2 valid -> out_src=2 every cycle.
- Round-robin fairness under stall: ch0 and ch3 valid, ptr=1, out_prdy toggling 1/0 -> grants alternate 3,0,3,0; pointer advances only on loads.
